// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one add/sub/and/or ALU between two valid/ready requesters.
// Define ALU_SCHED_ZERO_EN to add the registered resp_zero flag.
module alu_rr_sched #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_opnd1,
    input  logic [N-1:0] req0_opnd2,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_opnd1,
    input  logic [N-1:0] req1_opnd2,
    input  logic [1:0]   req1_op,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_data,
`ifdef ALU_SCHED_ZERO_EN
    output logic         resp_zero,
`endif
    output logic         resp_id
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e       state_q;
    logic         last_q;
    logic [N-1:0] opnd1_q;
    logic [N-1:0] opnd2_q;
    logic [1:0]   op_q;
    logic         id_q;
    logic         resp_valid_q;
    logic [N-1:0] resp_data_q;
    logic         resp_id_q;
`ifdef ALU_SCHED_ZERO_EN
    logic         resp_zero_q;
`endif

    logic         gnt_valid;
    logic         gnt_id;
    logic [N-1:0] alu_res;

    // On a tie the requester not granted last wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (req0_valid && req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_q;
            end else if (req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_valid && !gnt_id;
    assign req1_ready = gnt_valid && gnt_id;

    always_comb begin
        alu_res = '0;
        case (op_q)
            2'b00:   alu_res = opnd1_q + opnd2_q;
            2'b01:   alu_res = opnd1_q - opnd2_q;
            2'b10:   alu_res = opnd1_q & opnd2_q;
            default: alu_res = opnd1_q | opnd2_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            opnd1_q      <= '0;
            opnd2_q      <= '0;
            op_q         <= 2'b00;
            id_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
`ifdef ALU_SCHED_ZERO_EN
            resp_zero_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        opnd1_q <= gnt_id ? req1_opnd1 : req0_opnd1;
                        opnd2_q <= gnt_id ? req1_opnd2 : req0_opnd2;
                        op_q    <= gnt_id ? req1_op : req0_op;
                        id_q    <= gnt_id;
                        last_q  <= gnt_id;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    resp_data_q  <= alu_res;
                    resp_id_q    <= id_q;
`ifdef ALU_SCHED_ZERO_EN
                    resp_zero_q  <= (alu_res == '0);
`endif
                    resp_valid_q <= 1'b1;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
`ifdef ALU_SCHED_ZERO_EN
    assign resp_zero  = resp_zero_q;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: per-cycle transaction-level model plus directed vectors.
module tb_alu_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0] op0 = '0, op1 = '0;
    logic       resp_ready = 1'b1;
    logic       req0_ready, req1_ready, resp_valid, resp_id;
    logic [7:0] resp_data;
`ifdef ALU_SCHED_ZERO_EN
    logic       resp_zero;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b1;

    alu_rr_sched #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_ready (req0_ready),
        .req0_opnd1 (a0),
        .req0_opnd2 (b0),
        .req0_op    (op0),
        .req1_valid (v1),
        .req1_ready (req1_ready),
        .req1_opnd1 (a1),
        .req1_opnd2 (b1),
        .req1_op    (op1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
`ifdef ALU_SCHED_ZERO_EN
        .resp_zero  (resp_zero),
`endif
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_alu(input logic [1:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        int s;
        case (op)
            2'd0:    s = (int'(a) + int'(b)) % 256;
            2'd1:    s = (int'(a) - int'(b) + 256) % 256;
            2'd2:    s = int'(a & b);
            default: s = int'(a | b);
        endcase
        return s[7:0];
    endfunction

    // Model: an accepted op is outstanding for age cycles; response is due from age 2 on.
    bit         m_acc = 1'b0;
    int         m_age = 0;
    logic       m_last = 1'b1;
    logic       m_id = 1'b0;
    logic [7:0] m_res = '0;

    always @(negedge clk) begin
        logic gv, g, ev;
        if (mon_en) begin
            gv = 1'b0;
            g  = 1'b0;
            if (!rst && !m_acc) begin
                if (v0 && v1) begin
                    gv = 1'b1;
                    g  = ~m_last;
                end else if (v0) begin
                    gv = 1'b1;
                end else if (v1) begin
                    gv = 1'b1;
                    g  = 1'b1;
                end
            end
            ev = m_acc && (m_age >= 2);
            chk("req0_ready", 32'(req0_ready), 32'(gv && !g));
            chk("req1_ready", 32'(req1_ready), 32'(gv && g));
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            if (ev) begin
                chk("resp_data", 32'(resp_data), 32'(m_res));
                chk("resp_id", 32'(resp_id), 32'(m_id));
`ifdef ALU_SCHED_ZERO_EN
                chk("resp_zero", 32'(resp_zero), 32'(m_res == 8'h00));
`endif
            end
            if (rst) begin
                m_acc  = 1'b0;
                m_age  = 0;
                m_last = 1'b1;
            end else if (gv) begin
                m_acc  = 1'b1;
                m_age  = 1;
                m_id   = g;
                m_last = g;
                m_res  = g ? model_alu(op1, a1, b1) : model_alu(op0, a0, b0);
            end else if (ev && resp_ready) begin
                m_acc = 1'b0;
            end else if (m_acc && m_age < 2) begin
                m_age++;
            end
        end
    end

    task automatic wait_ready(input int id);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_resp(output int lat);
        bit ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("resp_wait", 32'(ok), 32'd1);
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [7:0] exp);
        int lat;
        if (id == 0) begin
            v0 = 1'b1; a0 = a; b0 = b; op0 = op;
        end else begin
            v1 = 1'b1; a1 = a; b1 = b; op1 = op;
        end
        wait_ready(id);
        @(posedge clk) #1;
        v0 = 1'b0;
        v1 = 1'b0;
        wait_resp(lat);
        chk("latency", 32'(lat), 32'd2);
        chk("op_data", 32'(resp_data), 32'(exp));
        chk("op_id", 32'(resp_id), 32'(id));
`ifdef ALU_SCHED_ZERO_EN
        chk("op_zero", 32'(resp_zero), 32'(exp == 8'h00));
`endif
        @(posedge clk) #1;
    endtask

    initial begin
        int lat;
        logic [7:0] hold_d;
        logic hold_id;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_data", 32'(resp_data), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_rdy", 32'({req0_ready, req1_ready}), 32'd0);
`ifdef ALU_SCHED_ZERO_EN
        chk("rst_zero", 32'(resp_zero), 32'd1);
`endif
        @(posedge clk) #1;
        rst = 1'b0;

        // single op, wrap and sub
        do_op(0, 8'h7F, 8'h01, 2'b00, 8'h80);
        @(negedge clk);
        chk("idle_after", 32'(resp_valid), 32'd0);
        @(posedge clk) #1;
        do_op(1, 8'h03, 8'h05, 2'b01, 8'hFE);
        do_op(1, 8'hFF, 8'h01, 2'b00, 8'h00);

        // tie from reset: grants alternate starting with requester 0
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        v0 = 1'b1; a0 = 8'hF0; b0 = 8'h3C; op0 = 2'b10;
        v1 = 1'b1; a1 = 8'hF0; b1 = 8'h0F; op1 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            bit ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("tie_wait", 32'(ok), 32'd1);
            chk("tie_grant", 32'(req1_ready), 32'(k % 2));
            chk("tie_onehot", 32'(req0_ready && req1_ready), 32'd0);
            wait_resp(lat);
            chk("tie_data", 32'(resp_data), (k % 2 == 1) ? 32'hFF : 32'h30);
        end
        @(posedge clk) #1;
        v0 = 1'b0;
        v1 = 1'b0;

        // backpressure with a requester-1 request that is withdrawn while busy
        resp_ready = 1'b0;
        v0 = 1'b1; a0 = 8'h10; b0 = 8'h01; op0 = 2'b01;
        wait_ready(0);
        @(posedge clk) #1;
        v0 = 1'b0;
        v1 = 1'b1;
        wait_resp(lat);
        hold_d  = resp_data;
        hold_id = resp_id;
        chk("bp_data", 32'(hold_d), 32'h0F);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk) #1;
            if (i == 2) v1 = 1'b0;
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_stable", 32'({resp_id, resp_data}), 32'({hold_id, hold_d}));
            chk("bp_rdy", 32'({req0_ready, req1_ready}), 32'd0);
        end
        @(posedge clk) #1;
        resp_ready = 1'b1;
        v0 = 1'b1; a0 = 8'h02; b0 = 8'h01; op0 = 2'b00;
        @(negedge clk);
        chk("hs_no_accept", 32'(req0_ready), 32'd0);
        @(negedge clk);
        chk("hs_next_accept", 32'(req0_ready), 32'd1);
        @(posedge clk) #1;
        v0 = 1'b0;
        wait_resp(lat);
        chk("after_bp_data", 32'(resp_data), 32'h03);
        @(posedge clk) #1;
        v0 = 1'b1;
        v1 = 1'b1;
        @(negedge clk);
        chk("ptr_tie_r1", 32'(req1_ready), 32'd1);
        @(posedge clk) #1;
        v0 = 1'b0;
        v1 = 1'b0;
        wait_resp(lat);
        @(posedge clk) #1;

        // reset during EXEC discards the op and restores the pointer
        v0 = 1'b1; a0 = 8'h01; b0 = 8'h01; op0 = 2'b00;
        wait_ready(0);
        @(posedge clk) #1;
        v0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_data", 32'(resp_data), 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        v0 = 1'b1; a0 = 8'h55; b0 = 8'h0A; op0 = 2'b11;
        v1 = 1'b1;
        @(negedge clk);
        chk("rst_tie_r0", 32'({req0_ready, req1_ready}), 32'b10);
        @(posedge clk) #1;
        v0 = 1'b0;
        v1 = 1'b0;
        wait_resp(lat);
        chk("rst_tie_data", 32'(resp_data), 32'h5F);
        repeat (3) @(posedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_rr_sched.md
# alu_rr_sched

Round-robin scheduler that shares one N-bit, four-function ALU (add, sub, and, or) between two requesters. Each requester issues operations over a valid/ready request channel. The block grants one request at a time, sequences it through a registered execute stage, and returns the result on a single shared response channel tagged with the requester ID. It sits between the two client engines and the shared arithmetic resource.

## Interface
- N, default 8: operand and result width in bits (N ≥ 1)
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, synchronous and active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_opnd1, req0_opnd2  in  N  requester 0 operands
- req0_op  in  2  requester 0 opcode: 00 add, 01 sub, 10 and, 11 or
- req1_valid, req1_ready, req1_opnd1, req1_opnd2, req1_op: same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  N  result
- resp_id  out  1  requester that issued the result
- resp_zero  out  1  resp_data == 0; present only with ALU_SCHED_ZERO_EN

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant one valid requester. If both are valid, grant the one not granted last.
  - reqX_ready is combinational and equals `grant==X`. It is asserted only in IDLE.
  - On accept: latch opnd1, opnd2, op and id; update the last-grant pointer; go to EXEC.
- EXEC: compute from the latched operands and register the result into resp_data. Go to RESP.
- RESP:
  - Hold resp_valid=1 with resp_data and resp_id stable until resp_ready=1.
  - On handshake, go to IDLE. No new request is accepted in the handshake cycle.
- Arithmetic is modulo 2^N. Carry and borrow are discarded.
  - sub is opnd1 − opnd2 in two's complement, wrapped. Example: 8'h03 − 8'h05 = 8'hFE.
  - and and or are bitwise.
- Request inputs are ignored outside IDLE. A requester keeps valid and operands stable until its ready pulses.
- Dropping reqX_valid before grant is legal. That requester is skipped and the pointer does not move.

## Timing
- Reset values: req0_ready=0, req1_ready=0, resp_valid=0, resp_data=0, resp_id=0, resp_zero=1 (when compiled in), last-grant pointer=1.
  - With pointer=1, requester 0 wins the first tie.
- Latency:
  - Accept in cycle T (IDLE).
  - EXEC in T+1.
  - resp_valid first high in T+2.
  - With resp_ready held high, the handshake happens in T+2, IDLE is T+3, and the next accept can occur in T+3.
  - Peak throughput is one operation per 3 cycles.
- Backpressure: resp_ready low holds RESP indefinitely. Both reqX_ready stay 0 meanwhile.
- Simultaneous requests: only one ready pulses per cycle. The other requester is served on the next IDLE if it is still valid. No requester waits more than one foreign operation.
- Reset mid-operation: rst high at any state returns to IDLE at the next edge.
  - Any in-flight operation or pending response is discarded (resp_valid=0).
  - The pointer returns to 1.
- The opcode is always one of four defined values. No X propagation from opcode decode: the case statement is full.

## Configuration
- ALU_SCHED_ZERO_EN
  - Defined: the resp_zero port exists. It is registered in EXEC alongside resp_data and is valid whenever resp_valid=1.
  - Undefined: no resp_zero port and no compare logic. All other behaviour is identical.

## Test plan
- Single op, N=8: req0 add 8'h7F+8'h01 with resp_ready=1.
  - Expect req0_ready at T.
  - Expect resp_valid at T+2 with resp_data=8'h80, resp_id=0, then IDLE at T+3.
- Wrap/sub: req1 sub 8'h03−8'h05 → resp_data=8'hFE, resp_id=1. Also req1 add 8'hFF+8'h01 → 8'h00 and resp_zero=1 (macro defined).
- Tie/round-robin: both valid from reset with resp_ready=1.
  - req0 is granted first: and 8'hF0&8'h3C → 8'h30.
  - Next IDLE grants req1: or 8'hF0|8'h0F → 8'hFF.
  - Grants alternate 0,1,0,1 over 4 ops.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP.
  - resp_valid, resp_data and resp_id stay stable; both reqX_ready stay 0.
  - Raise resp_ready: the handshake completes and the next accept happens 1 cycle later.
- Reset mid-op: assert rst during EXEC.
  - Next cycle: IDLE, resp_valid=0, resp_data=0, pointer=1.
  - A subsequent tie grants req0.
- Withdrawn request: req1 valid for one IDLE cycle while busy, then dropped. No grant to req1, pointer unchanged, no spurious response.
